// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - arb_state_e      : arbiter FSM encoding (StIdle=0, StPend=1, StRd=2)
//   - DefAddrW/DefDataW: default memory address/data widths
//   - TagCore/TagAux   : owner tag carried alongside in-flight memory reads
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPend = 2'd1,
    StRd   = 2'd2
  } arb_state_e;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefDataW = 8;

  localparam logic TagCore = 1'b0;
  localparam logic TagAux  = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of every bus signal around the arbiter: core port, aux command port and memory port.
//   modport slave  : the arbiter's view (serves core/aux, drives memory)
//   modport master : the surroundings' view (core, aux requester and memory together)
// Parameters: ADDR_W (address width), DATA_W (data width).
interface mem_arb_if import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  // Core side
  logic              core_en_store;
  logic              core_en_load;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_store;
  logic [DATA_W-1:0] core_load;

  // Aux command side
  logic              aux_req;
  logic              aux_ready;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_done;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_starved;

  // Memory side
  logic              mem_en_store;
  logic              mem_en_load;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_store;
  logic [DATA_W-1:0] mem_load;

  modport slave (
    input  core_en_store, core_en_load, core_addr, core_store,
    output core_load,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_ready, aux_done, aux_rdata, aux_starved,
    output mem_en_store, mem_en_load, mem_addr, mem_store,
    input  mem_load
  );

  modport master (
    output core_en_store, core_en_load, core_addr, core_store,
    input  core_load,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_ready, aux_done, aux_rdata, aux_starved,
    input  mem_en_store, mem_en_load, mem_addr, mem_store,
    output mem_load
  );

endinterface

// File: rtl/mem_arb_rdpipe.sv
// Read-return tracker: a READ_LAT-deep shift register of {valid, tag} for every load sent to
// memory. aux_hit_o is high in the cycle mem_load carries the data of an aux-issued read.
// Ports:
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset (clears all in-flight tags)
//   push_i    : a load is issued to memory this cycle
//   tag_i     : owner of that load (TagCore / TagAux)
//   aux_hit_o : mem_load holds aux read data this cycle
module mem_arb_rdpipe import mem_arb_pkg::*; #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic tag_i,
  output logic aux_hit_o
);

  logic [READ_LAT-1:0] valid_q, valid_d;
  logic [READ_LAT-1:0] tag_q, tag_d;

  always_comb begin
    valid_d    = '0;
    tag_d      = '0;
    valid_d[0] = push_i;
    tag_d[0]   = tag_i;
    for (int i = 1; i < int'(READ_LAT); i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  // Selecting on the tag keeps a core read returning in the same window from being taken as aux
  assign aux_hit_o = valid_q[READ_LAT-1] & (tag_q[READ_LAT-1] == TagAux);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between the core (always wins, zero latency) and an aux
// requester (loader / debug master). One aux command is buffered at a time and issued into a
// cycle the core leaves idle; completion is signalled by a one-cycle aux_done pulse.
// Ports:
//   clk           : clock, all state on posedge
//   rst           : synchronous active-low reset
//   bus           : mem_arb_if.slave (core port, aux command port, memory port)
//   aux_conflicts : [MEM_ARB_STATS_EN only] saturating count of PEND cycles blocked by the core
//   aux_grants    : [MEM_ARB_STATS_EN only] wrapping count of issued aux operations
// Build option: define MEM_ARB_STATS_EN to add the two statistics counters and ports.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  mem_arb_if.slave    bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] aux_conflicts,
  output logic [15:0] aux_grants
`endif
);

  localparam int unsigned   WaitW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] store_hold_q;

  logic core_busy;
  logic pend;
  logic aux_issue;
  logic aux_hit;

  assign core_busy = bus.core_en_store | bus.core_en_load;
  assign pend      = (state_q == StPend);
  // No aux issue in a reset cycle: the command is being dropped, so it must not reach memory
  assign aux_issue = rst & pend & ~core_busy;

  // Memory port mux: core first, then the latched aux command, otherwise hold address/data
  always_comb begin
    bus.mem_en_store = 1'b0;
    bus.mem_en_load  = 1'b0;
    bus.mem_addr     = addr_hold_q;
    bus.mem_store    = store_hold_q;
    if (core_busy) begin
      bus.mem_en_store = bus.core_en_store;
      bus.mem_en_load  = bus.core_en_load;
      bus.mem_addr     = bus.core_addr;
      bus.mem_store    = bus.core_store;
    end else if (aux_issue) begin
      bus.mem_en_store = cmd_we_q;
      bus.mem_en_load  = ~cmd_we_q;
      bus.mem_addr     = cmd_addr_q;
      bus.mem_store    = cmd_wdata_q;
    end
  end

  mem_arb_rdpipe #(
    .READ_LAT (READ_LAT)
  ) u_rdpipe (
    .clk_i     (clk),
    .rst_ni    (rst),
    .push_i    (bus.mem_en_load),
    .tag_i     (core_busy ? TagCore : TagAux),
    .aux_hit_o (aux_hit)
  );

  // FSM next state, command latch, completion and starvation counter
  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    wait_d      = wait_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      StIdle: begin
        if (bus.aux_req) begin
          cmd_we_d    = bus.aux_we;
          cmd_addr_d  = bus.aux_addr;
          cmd_wdata_d = bus.aux_wdata;
          state_d     = StPend;
        end
      end
      StPend: begin
        if (aux_issue) begin
          wait_d  = '0;
          done_d  = cmd_we_q;
          state_d = cmd_we_q ? StIdle : StRd;
        end else if (core_busy && (wait_q < WaitMax)) begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StRd: begin
        if (aux_hit) begin
          rdata_d = bus.mem_load;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      wait_q      <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      wait_q      <= wait_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  // Last driven address/data, so idle cycles do not toggle the memory pins. A core access in a
  // reset cycle still counts as driven because reset leaves the core path untouched.
  always_ff @(posedge clk) begin
    if (!rst && !core_busy) begin
      addr_hold_q  <= '0;
      store_hold_q <= '0;
    end else begin
      addr_hold_q  <= bus.mem_addr;
      store_hold_q <= bus.mem_store;
    end
  end

  assign bus.core_load   = bus.mem_load;
  assign bus.aux_ready   = (state_q == StIdle);
  assign bus.aux_done    = done_q;
  assign bus.aux_rdata   = rdata_q;
  assign bus.aux_starved = (wait_q >= WaitMax);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflicts_q, conflicts_d;
  logic [15:0] grants_q, grants_d;

  always_comb begin
    conflicts_d = conflicts_q;
    grants_d    = grants_q;
    if (pend && core_busy && (conflicts_q != 16'hFFFF)) begin
      conflicts_d = conflicts_q + 16'd1;
    end
    if (aux_issue) begin
      grants_d = grants_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflicts_q <= '0;
      grants_q    <= '0;
    end else begin
      conflicts_q <= conflicts_d;
      grants_q    <= grants_d;
    end
  end

  assign aux_conflicts = conflicts_q;
  assign aux_grants    = grants_q;
`endif

endmodule
